// File: rtl/ifetch_unit.sv
// ifetch_unit: sequential fetch PC generator with in-order response pairing, instruction FIFO and redirect flush
module ifetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          FIFO_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        imem_resp_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data,
    input  logic        inst_ready
);
    localparam int CW = $clog2(2 * FIFO_DEPTH + 1);
    localparam int TW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int FW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;

    logic [31:0]   fetch_pc, fpc_nx;
    logic [CW-1:0] outstanding, drop_cnt, count, out_nx, drop_nx, cnt_nx;
    logic          stale, stale_nx, req_hs, resp_hs, pending, push, pop, issue;
    logic [31:0]   tag_q [MAX_OUTSTANDING];
    logic [63:0]   fifo_q [FIFO_DEPTH];
    logic [TW-1:0] tag_wp, tag_rp;
    logic [FW-1:0] wp, rp;

    assign inst_valid = count != '0;
    assign {inst_pc, inst_data} = inst_valid ? fifo_q[rp] : '0;

    // stale marks a request that was pending at a redirect; its response must be dropped once accepted
    always_comb begin
        req_hs   = imem_req_valid && imem_req_ready;
        resp_hs  = imem_resp_valid && imem_resp_ready && outstanding != '0;
        pending  = imem_req_valid && !imem_req_ready;
        push     = resp_hs && drop_cnt == '0 && !redirect_valid;
        pop      = inst_valid && inst_ready && !redirect_valid;
        out_nx   = outstanding + CW'(req_hs) - CW'(resp_hs);
        drop_nx  = redirect_valid ? out_nx : drop_cnt - CW'(resp_hs && drop_cnt != '0) + CW'(req_hs && stale);
        stale_nx = redirect_valid ? pending : stale && !req_hs;
        cnt_nx   = redirect_valid ? '0 : count + CW'(push) - CW'(pop);
        fpc_nx   = redirect_valid ? redirect_pc & 32'hFFFF_FFFC : (req_hs && !stale) ? fetch_pc + 32'd4 : fetch_pc;
        issue    = !pending && !redirect_valid && out_nx < CW'(MAX_OUTSTANDING)
                   && (out_nx - drop_nx) + cnt_nx < CW'(FIFO_DEPTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_req_valid  <= 1'b0;
            imem_req_addr   <= RESET_PC;
            imem_resp_ready <= 1'b0;
            fetch_pc        <= RESET_PC;
            outstanding     <= '0;
            drop_cnt        <= '0;
            count           <= '0;
            stale           <= 1'b0;
            tag_wp          <= '0;
            tag_rp          <= '0;
            wp              <= '0;
            rp              <= '0;
        end else begin
            imem_req_valid  <= issue || pending;
            imem_req_addr   <= issue ? fpc_nx : imem_req_addr;
            imem_resp_ready <= 1'b1;
            fetch_pc        <= fpc_nx;
            outstanding     <= out_nx;
            drop_cnt        <= drop_nx;
            count           <= cnt_nx;
            stale           <= stale_nx;
            if (req_hs) tag_wp <= tag_wp == TW'(MAX_OUTSTANDING - 1) ? '0 : tag_wp + 1'b1;
            if (resp_hs) tag_rp <= tag_rp == TW'(MAX_OUTSTANDING - 1) ? '0 : tag_rp + 1'b1;
            if (redirect_valid) begin
                wp <= '0;
                rp <= '0;
            end else begin
                if (push) wp <= wp == FW'(FIFO_DEPTH - 1) ? '0 : wp + 1'b1;
                if (pop) rp <= rp == FW'(FIFO_DEPTH - 1) ? '0 : rp + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_hs) tag_q[tag_wp] <= imem_req_addr;
        if (push) fifo_q[wp] <= {tag_q[tag_rp], imem_resp_data};
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(imem_resp_valid && imem_resp_ready && outstanding == '0));
    assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && count == CW'(FIFO_DEPTH)));
endmodule
